// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command-frame controller.
// CRC constants follow the reader-to-tag CRC-16: CCITT polynomial, all-ones preset.
// A received frame with its complemented CRC appended leaves the 0x1D0F residue.
package cmd_frame_pkg;

  localparam int          MAX_BITS_DEF  = 64;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_T1_WAIT = 3'd3,
    ST_REPLY   = 3'd4
  } state_e;

  // One serial CRC-16 step, MSB-first shift register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cmd_crc16_ser.sv
// Serial CRC-16 register: clear to preset, advance one bit per enable.
// Built only when CMD_CRC16_CHK_EN is defined; otherwise this file is empty.
`ifdef CMD_CRC16_CHK_EN
module cmd_crc16_ser
  import cmd_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  // Clear wins over a simultaneous bit so a restart always begins from the preset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC16_PRESET;
    end else if (clr_i) begin
      crc_q <= CRC16_PRESET;
    end else if (en_i) begin
      crc_q <= crc16_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule
`endif

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: assembles demodulated bits into a frame, hands it to the
// decoder, counts down T1 and strobes the modulator for the reply.
// Optional build macro CMD_CRC16_CHK_EN adds a serial CRC-16 check of each frame.
//
// Decoder handshake: o_cmd_valid rises the cycle after the frame closes and stays high,
// with o_cmd_bits/o_cmd_len/o_cmd_pre stable, until a cycle with i_cmd_ready high; the
// frame is transferred in that cycle and o_cmd_valid is low from the next cycle on.
module cmd_frame_ctrl
  import cmd_frame_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int LEN_W    = 7,
  parameter int T1_W     = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_data_dem,
  input  logic                i_valid_dem,
  input  logic                i_newcmd_dem,
  input  logic                i_preamble_dem,
  input  logic [T1_W-1:0]     i_t1_dem,
  input  logic                i_t1_start_dem,
  output logic [MAX_BITS-1:0] o_cmd_bits,
  output logic [LEN_W-1:0]    o_cmd_len,
  output logic                o_cmd_pre,
  output logic                o_cmd_valid,
  input  logic                i_cmd_ready,
  input  logic                i_reply_req,
  output logic                o_reply_start,
  input  logic                i_reply_done,
  output logic                o_busy,
  output logic                o_overflow,
  output logic                o_t1_miss,
  output logic                o_crc_ok
);

  state_e              state_q;
  logic [MAX_BITS-1:0] buf_q;
  logic [LEN_W-1:0]    len_q;
  logic [T1_W-1:0]     cnt_q;
  logic                pre_q;
  logic                valid_q;
  logic                ovf_q;
  logic                miss_q;
  logic                req_flag_q;

  // Helper values for the append / close / countdown paths.
  logic [MAX_BITS-1:0] buf_app;
  logic [LEN_W-1:0]    len_inc;
  logic [LEN_W-1:0]    len_close;
  logic                at_max;
  logic [T1_W-1:0]     cnt_dec;
  logic                restart;

  assign buf_app   = {buf_q[MAX_BITS-2:0], i_data_dem};
  assign len_inc   = len_q + 1'b1;
  assign len_close = i_valid_dem ? len_inc : len_q;
  assign at_max    = (len_q == LEN_W'(MAX_BITS));
  assign cnt_dec   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
  // A new command aborts any frame in progress; the reply phase is half-duplex.
  assign restart   = i_newcmd_dem && (state_q != ST_REPLY);

`ifdef CMD_CRC16_CHK_EN
  logic [15:0] crc_w;
  logic [15:0] crc_close;
  logic        crc_en;
  logic        crc_ok_q;

  assign crc_en    = (state_q == ST_RECV) && i_valid_dem && !i_newcmd_dem && !at_max;
  // A bit arriving with the end-of-frame strobe must be folded into the check.
  assign crc_close = i_valid_dem ? crc16_step(crc_w, i_data_dem) : crc_w;

  cmd_crc16_ser u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (restart),
    .en_i  (crc_en),
    .bit_i (i_data_dem),
    .crc_o (crc_w)
  );

  // CRC verdict is latched at frame close; short frames cannot carry a valid CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_ok_q <= 1'b0;
    end else if (restart) begin
      crc_ok_q <= 1'b0;
    end else if (state_q == ST_RECV && i_t1_start_dem && !(i_valid_dem && at_max)) begin
      crc_ok_q <= (len_close > LEN_W'(16)) && (crc_close == CRC16_RESIDUE);
    end
  end

  assign o_crc_ok = crc_ok_q;
`else
  assign o_crc_ok = 1'b1;
`endif

  // Main frame FSM with its registered outputs, buffer, length and T1 counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      pre_q      <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      miss_q     <= 1'b0;
      req_flag_q <= 1'b0;
    end else begin
      ovf_q  <= 1'b0;
      // A reply request with no frame pending is too late by definition.
      miss_q <= (state_q == ST_IDLE) && i_reply_req;
      if (restart) begin
        state_q    <= ST_RECV;
        buf_q      <= '0;
        len_q      <= '0;
        valid_q    <= 1'b0;
        req_flag_q <= 1'b0;
      end else begin
        case (state_q)
          ST_RECV: begin
            if (i_valid_dem && at_max) begin
              ovf_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              if (i_valid_dem) begin
                buf_q <= buf_app;
                len_q <= len_inc;
              end
              if (i_t1_start_dem) begin
                if (len_close == '0) begin
                  state_q <= ST_IDLE;
                end else begin
                  cnt_q   <= i_t1_dem;
                  pre_q   <= i_preamble_dem;
                  valid_q <= 1'b1;
                  state_q <= ST_HOLD;
                end
              end
            end
          end
          ST_HOLD: begin
            cnt_q <= cnt_dec;
            if (i_reply_req) req_flag_q <= 1'b1;
            if (i_cmd_ready) begin
              valid_q <= 1'b0;
              state_q <= ST_T1_WAIT;
            end
          end
          ST_T1_WAIT: begin
            if (cnt_q == '0) begin
              req_flag_q <= 1'b0;
              state_q    <= (req_flag_q || i_reply_req) ? ST_REPLY : ST_IDLE;
            end else begin
              cnt_q <= cnt_dec;
              if (i_reply_req) req_flag_q <= 1'b1;
            end
          end
          ST_REPLY: begin
            if (i_reply_done) state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // The reply strobe fires in the very cycle T1 expires so the modulator starts on time;
  // a request arriving in that same cycle still counts.
  assign o_reply_start = (state_q == ST_T1_WAIT) && !i_newcmd_dem && (cnt_q == '0) &&
                         (req_flag_q || i_reply_req);

  assign o_busy      = (state_q != ST_IDLE);
  assign o_cmd_bits  = buf_q;
  assign o_cmd_len   = len_q;
  assign o_cmd_pre   = pre_q;
  assign o_cmd_valid = valid_q;
  assign o_overflow  = ovf_q;
  assign o_t1_miss   = miss_q;

endmodule
